// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - serial framed-image loader writing 16-bit words into instruction memory
//
// Parses SYNC, CNT_HI, CNT_LO, N words (high byte first), CHK from a byte stream
// and writes the words to consecutive addresses starting at 0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    received byte and its valid flag
//   in_ready            loader accepts a byte this cycle (low only while writing)
//   mem_we/addr/din     single-cycle write strobe, 9-bit address, 16-bit word
//   cpu_hold            holds the CPU in reset until an image has loaded and verified
//   done / error        last frame verified / last frame rejected
module instruction_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;      // 10 bits so that a count of 512 is reachable
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  hi_q, hi_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        take;
    logic [15:0] count_full;
    logic [9:0]  addr_inc;

    assign take       = in_valid && in_ready_q;
    assign count_full = {cnt_q[15:8], in_data};
    assign addr_inc   = addr_q + 10'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            // Idle and both terminal states behave alike: only a sync byte matters.
            S_IDLE, S_DONE, S_ERR: begin
                if (take && in_data == SYNC_BYTE) begin
                    state_d    = S_CNT_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                    addr_d     = 10'd0;
                    acc_d      = 8'd0;
                end
            end
            S_CNT_HI: begin
                if (take) begin
                    cnt_d[15:8] = in_data;
                    state_d     = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (take) begin
                    cnt_d = count_full;
                    if (count_full == 16'd0 || count_full > MAX_N) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (take) begin
                    hi_d    = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Strobe is registered here so it is high exactly during the WRITE cycle.
                if (take) begin
                    acc_d      = acc_q ^ in_data;
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q[8:0];
                    mem_din_d  = {hi_q, in_data};
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d = addr_inc;
                if ({6'd0, addr_inc} == cnt_q) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (take) begin
                    if (in_data == acc_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so it never depends on in_valid combinationally.
        in_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            addr_q     <= 10'd0;
            acc_q      <= 8'd0;
            hi_q       <= 8'd0;
            in_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 9'd0;
            mem_din_q  <= 16'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_din;
    logic        cpu_hold;
    logic        done;
    logic        error;

    instruction_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [24:0] exp_q[$];
    logic [15:0] words[$];
    logic        prev_we = 1'b0;
    logic [8:0]  last_addr = 9'd0;

    always @(posedge clk) cycle <= cycle + 1;

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n) begin
            checks++;
            if (in_ready !== ~mem_we) begin
                errors++;
                $display("FAIL ready_vs_we: in_ready=%b mem_we=%b (in_ready must be low exactly in write cycles)", in_ready, mem_we);
            end
            if (mem_we === 1'b1) begin
                checks++;
                if (prev_we) begin
                    errors++;
                    $display("FAIL we_pulse: mem_we high two cycles in a row");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h din=%h, none expected", mem_addr, mem_din);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_din} !== e) begin
                        errors++;
                        $display("FAIL write: got addr=%h din=%h, expected addr=%h din=%h", mem_addr, mem_din, e[24:16], e[15:0]);
                    end
                end
                last_addr = mem_addr;
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        @(negedge clk);
        if (max_gap > 0) begin
            n = $urandom_range(0, max_gap);
            in_valid = 1'b0;
            repeat (n) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h never accepted", b);
        end else begin
            @(posedge clk);
        end
    endtask

    // Sends SYNC, count, the words queue and its checksum (xor'ed with chk_flip);
    // pushes the expected writes. Returns cycle stamps of the sync and checksum transfers.
    task automatic send_frame(input int gap, input logic [7:0] chk_flip, output int t_first, output int t_last);
        logic [15:0] n;
        logic [7:0]  chk;
        logic [15:0] w;
        n   = 16'(words.size());
        chk = 8'd0;
        send_byte(8'hA5, gap);
        t_first = cycle;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int i = 0; i < words.size(); i++) begin
            logic [8:0] a;
            a = 9'(i);
            w = words[i];
            exp_q.push_back({a, w});
            chk = chk ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], gap);
            send_byte(w[7:0], gap);
        end
        send_byte(chk ^ chk_flip, gap);
        t_last = cycle;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 9'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (mem_din !== 16'd0) begin errors++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load;
        int t0, t1;
        words = '{16'h1234, 16'hABCD};
        send_frame(0, 8'h00, t0, t1);
        checks += 5;
        if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL load_error: got %b want 0", error); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load_cpu_hold: got %b want 0", cpu_hold); end
        if (t1 - t0 !== 9) begin errors++; $display("FAIL load_frame_time: got %0d cycles want 9 after sync", t1 - t0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL load_writes_missing: %0d pending", exp_q.size()); end
    endtask

    task automatic test_bad_checksum;
        int t0, t1;
        words = '{16'h1234, 16'hABCD};
        send_frame(0, 8'h01, t0, t1);
        checks += 4;
        if (done !== 1'b0) begin errors++; $display("FAIL badchk_done: got %b want 0", done); end
        if (error !== 1'b1) begin errors++; $display("FAIL badchk_error: got %b want 1", error); end
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL badchk_cpu_hold: got %b want 1", cpu_hold); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL badchk_writes_missing: %0d pending", exp_q.size()); end
    endtask

    task automatic test_resync_after_err;
        int t0, t1;
        words = '{16'h0F0F, 16'h5AA5, 16'hFFFF};
        send_frame(0, 8'h00, t0, t1);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL after_err_done: got %b want 1", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL after_err_error: got %b want 0", error); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL after_err_cpu_hold: got %b want 0", cpu_hold); end
    endtask

    task automatic test_count_bounds;
        int t0, t1;
        logic [15:0] bad_n[2];
        bad_n[0] = 16'h0000;
        bad_n[1] = 16'h0201;
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hA5, 0);
            send_byte(bad_n[k][15:8], 0);
            send_byte(bad_n[k][7:0], 0);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks += 3;
            if (error !== 1'b1) begin errors++; $display("FAIL bounds_error n=%h: got %b want 1", bad_n[k], error); end
            if (done !== 1'b0) begin errors++; $display("FAIL bounds_done n=%h: got %b want 0", bad_n[k], done); end
            if (cpu_hold !== 1'b1) begin errors++; $display("FAIL bounds_cpu_hold n=%h: got %b want 1", bad_n[k], cpu_hold); end
        end
        words.delete();
        for (int i = 0; i < 512; i++) words.push_back(16'($urandom));
        send_frame(0, 8'h00, t0, t1);
        checks += 4;
        if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL max_error: got %b want 0", error); end
        if (last_addr !== 9'h1FF) begin errors++; $display("FAIL max_last_addr: got %h want 1ff", last_addr); end
        if (t1 - t0 !== 3 + 3 * 512) begin errors++; $display("FAIL max_frame_time: got %0d want %0d", t1 - t0, 3 + 3 * 512); end
    endtask

    task automatic test_garbage_resync;
        int t0, t1;
        send_byte(8'h3C, 0);
        send_byte(8'hFF, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL garbage_done: got %b want 1 (bytes must be discarded)", done); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL garbage_cpu_hold: got %b want 0", cpu_hold); end
        words = '{16'h1234, 16'hABCD};
        send_frame(0, 8'h00, t0, t1);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL garbage_load_done: got %b want 1", done); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL garbage_writes_missing: %0d pending", exp_q.size()); end
    endtask

    task automatic test_handshake;
        int t0, t1;
        words = '{16'hA5A5, 16'h00A5, 16'h1234, 16'hA500, 16'hBEEF, 16'h0001};
        send_frame(3, 8'h00, t0, t1);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL handshake_done: got %b want 1", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL handshake_error: got %b want 0", error); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL handshake_writes_missing: %0d pending", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame;
        int t0, t1;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({9'd0, 16'h1234});
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #6;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks += 8;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL midreset_first_write: %0d pending", exp_q.size()); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL midreset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 9'd0) begin errors++; $display("FAIL midreset_mem_addr: got %h want 0", mem_addr); end
        if (mem_din !== 16'd0) begin errors++; $display("FAIL midreset_mem_din: got %h want 0", mem_din); end
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL midreset_cpu_hold: got %b want 1", cpu_hold); end
        if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
        if (error !== 1'b0) begin errors++; $display("FAIL midreset_error: got %b want 0", error); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        words = '{16'hCAFE, 16'h0BAD, 16'hF00D};
        send_frame(0, 8'h00, t0, t1);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL after_reset_done: got %b want 1", done); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL after_reset_cpu_hold: got %b want 0", cpu_hold); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL after_reset_writes_missing: %0d pending", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_checksum();
        test_resync_after_err();
        test_count_bounds();
        test_garbage_resync();
        test_handshake();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
